debug_unit: RTL

//  Host-side controller that sequences the pipeline core over a byte link (UART rx/tx).

---
 rtl/debug_pkg.sv | 31 +++
 rtl/dbg_tx_serializer.sv | 78 +++++++
 rtl/debug_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the host debug controller: link command codes,
// special words, dump geometry and the controller state encoding.
package debug_pkg;

    localparam int unsigned INST_SZ        = 32;
    localparam int unsigned REG_SZ         = 5;
    localparam int unsigned BYTE_SZ        = 8;
    localparam int unsigned BYTES_PER_WORD = INST_SZ / BYTE_SZ;
    localparam int unsigned NUM_REGS       = 1 << REG_SZ;
    // PC word followed by every GPR
    localparam int unsigned DUMP_WORDS     = NUM_REGS + 1;
    localparam int unsigned DUMP_BYTES     = DUMP_WORDS * BYTES_PER_WORD;

    localparam logic [BYTE_SZ-1:0] CMD_LOAD    = 8'h4C;
    localparam logic [BYTE_SZ-1:0] CMD_RUN     = 8'h52;
    localparam logic [BYTE_SZ-1:0] CMD_STEP    = 8'h53;
    localparam logic [BYTE_SZ-1:0] CMD_DUMP    = 8'h44;
    localparam logic [BYTE_SZ-1:0] ERR_TIMEOUT = 8'hEE;
    localparam logic [INST_SZ-1:0] HALT_INSTR  = 32'h0000_003F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_STEP,
        ST_DUMP_ADDR,
        ST_DUMP_CAP,
        ST_DUMP_TX
    } state_e;

endpackage

// File: rtl/dbg_tx_serializer.sv
// Sends one 32-bit word as 4 link bytes, MSB first, honouring the
// transmitter start/done handshake.
//   i_word/i_load   word to send and 1-cycle load strobe (ignored while busy only by contract)
//   o_tx_data/o_tx_start  byte and 1-cycle start strobe to the transmitter
//   i_tx_done       1-cycle strobe, previous byte finished
//   o_word_done     1-cycle strobe after the last byte's done
module dbg_tx_serializer
    import debug_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [INST_SZ-1:0] i_word,
    input  logic               i_load,
    input  logic               i_tx_done,
    output logic [BYTE_SZ-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_word_done
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

    logic [INST_SZ-1:0] shift_q,     shift_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               active_q,    active_d;
    logic [BYTE_SZ-1:0] tx_data_q,   tx_data_d;
    logic               tx_start_q,  tx_start_d;
    logic               word_done_q, word_done_d;

    // Next byte is launched on load or on done of the previous one
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        word_done_d = 1'b0;
        if (i_load) begin
            tx_data_d  = i_word[INST_SZ-1 -: BYTE_SZ];
            shift_d    = i_word << BYTE_SZ;
            cnt_d      = '0;
            active_d   = 1'b1;
            tx_start_d = 1'b1;
        end else if (active_q && i_tx_done) begin
            if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
                active_d    = 1'b0;
                word_done_d = 1'b1;
            end else begin
                cnt_d      = cnt_q + CNT_W'(1);
                tx_data_d  = shift_q[INST_SZ-1 -: BYTE_SZ];
                shift_d    = shift_q << BYTE_SZ;
                tx_start_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            active_q    <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            word_done_q <= word_done_d;
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_word_done = word_done_q;

endmodule

// File: rtl/debug_unit.sv
// Host debug controller: loads programs into IMEM over the byte link,
// runs or single-steps the pipeline and dumps PC + 32 GPRs after each stop.
//   i_rx_data/i_rx_valid          received link bytes
//   o_tx_data/o_tx_start/i_tx_done transmit link handshake
//   o_write/o_instruction         IMEM write port
//   o_enable                      pipeline clock-enable
//   o_debug_addr/i_data           register-file debug read (1-cycle latency)
//   i_pc, i_halt                  pipeline status
//   o_busy                        low only when idle
// Optional: DBG_LOAD_TIMEOUT_EN adds an inter-byte timeout in LOAD that
// reports 8'hEE and returns to idle.
module debug_unit
    import debug_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256
`ifdef DBG_LOAD_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [BYTE_SZ-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [BYTE_SZ-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_write,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_enable,
    output logic [REG_SZ-1:0]  o_debug_addr,
    input  logic [INST_SZ-1:0] i_pc,
    input  logic [INST_SZ-1:0] i_data,
    input  logic               i_halt,
    output logic               o_busy
);

    localparam int unsigned BCNT_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned WCNT_W = $clog2(IMEM_DEPTH + 1);
    localparam int unsigned SLOT_W = $clog2(DUMP_WORDS);

    state_e             state_q,      state_d;
    logic [BCNT_W-1:0]  byte_cnt_q,   byte_cnt_d;
    logic [WCNT_W-1:0]  word_cnt_q,   word_cnt_d;
    logic [SLOT_W-1:0]  slot_q,       slot_d;
    logic               launched_q,   launched_d;
    logic [INST_SZ-1:0] instr_q,      instr_d;
    logic               write_q,      write_d;
    logic               enable_q,     enable_d;
    logic [REG_SZ-1:0]  debug_addr_q, debug_addr_d;
    logic               busy_q,       busy_d;

    logic               ser_load;
    logic [INST_SZ-1:0] ser_word;
    logic [BYTE_SZ-1:0] ser_tx_data;
    logic               ser_tx_start;
    logic               ser_word_done;

`ifdef DBG_LOAD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]    to_cnt_q,     to_cnt_d;
    logic               err_start_q,  err_start_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        slot_d       = slot_q;
        launched_d   = launched_q;
        instr_d      = instr_q;
        write_d      = 1'b0;
        enable_d     = 1'b0;
        debug_addr_d = debug_addr_q;
        ser_load     = 1'b0;
        ser_word     = i_pc;
`ifdef DBG_LOAD_TIMEOUT_EN
        to_cnt_d     = '0;
        err_start_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                byte_cnt_d = '0;
                word_cnt_d = '0;
                slot_d     = '0;
                launched_d = 1'b0;
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: state_d = ST_LOAD;
                        CMD_RUN: begin
                            state_d  = i_halt ? ST_DUMP_ADDR : ST_RUN;
                            enable_d = !i_halt;
                        end
                        CMD_STEP: begin
                            state_d  = i_halt ? ST_DUMP_ADDR : ST_STEP;
                            enable_d = !i_halt;
                        end
                        CMD_DUMP: state_d = ST_DUMP_ADDR;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (i_rx_valid) begin
                    instr_d = {instr_q[INST_SZ-BYTE_SZ-1:0], i_rx_data};
                    if (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
                        byte_cnt_d = '0;
                        write_d    = 1'b1;
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                        if (instr_d == HALT_INSTR ||
                            word_cnt_q == WCNT_W'(IMEM_DEPTH - 1)) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    end
                end
`ifdef DBG_LOAD_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ST_IDLE;
                    byte_cnt_d  = '0;
                    err_start_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            ST_RUN: begin
                // Enable drops on the same edge that samples halt
                if (i_halt) begin
                    state_d = ST_DUMP_ADDR;
                end else begin
                    enable_d = 1'b1;
                end
            end
            ST_STEP: state_d = ST_DUMP_ADDR;
            ST_DUMP_ADDR: begin
                // Slot 0 is the PC; slot n+1 reads GPR n
                debug_addr_d = REG_SZ'(slot_q - SLOT_W'(1));
                launched_d   = 1'b0;
                state_d      = ST_DUMP_CAP;
            end
            ST_DUMP_CAP: state_d = ST_DUMP_TX;
            ST_DUMP_TX: begin
                if (!launched_q) begin
                    ser_load   = 1'b1;
                    ser_word   = (slot_q == '0) ? i_pc : i_data;
                    launched_d = 1'b1;
                end else if (ser_word_done) begin
                    if (slot_q == SLOT_W'(DUMP_WORDS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        slot_d  = slot_q + SLOT_W'(1);
                        state_d = ST_DUMP_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            slot_q       <= '0;
            launched_q   <= 1'b0;
            instr_q      <= '0;
            write_q      <= 1'b0;
            enable_q     <= 1'b0;
            debug_addr_q <= '0;
            busy_q       <= 1'b0;
`ifdef DBG_LOAD_TIMEOUT_EN
            to_cnt_q     <= '0;
            err_start_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            slot_q       <= slot_d;
            launched_q   <= launched_d;
            instr_q      <= instr_d;
            write_q      <= write_d;
            enable_q     <= enable_d;
            debug_addr_q <= debug_addr_d;
            busy_q       <= busy_d;
`ifdef DBG_LOAD_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            err_start_q  <= err_start_d;
`endif
        end
    end

    dbg_tx_serializer u_ser (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_word      (ser_word),
        .i_load      (ser_load),
        .i_tx_done   (i_tx_done),
        .o_tx_data   (ser_tx_data),
        .o_tx_start  (ser_tx_start),
        .o_word_done (ser_word_done)
    );

`ifdef DBG_LOAD_TIMEOUT_EN
    // Error byte is only sent from LOAD, when the serializer is idle
    assign o_tx_start = ser_tx_start | err_start_q;
    assign o_tx_data  = err_start_q ? ERR_TIMEOUT : ser_tx_data;
`else
    assign o_tx_start = ser_tx_start;
    assign o_tx_data  = ser_tx_data;
`endif

    assign o_write       = write_q;
    assign o_instruction = instr_q;
    assign o_enable      = enable_q;
    assign o_debug_addr  = debug_addr_q;
    assign o_busy        = busy_q;

endmodule
